ss_oport_pck_arbiter: RTL and testbench
=======================================

// Module: ss_oport_pck_arbiter
// PURPOSE
//  Packet-level round-robin arbiter for one router output port shared by N flit sources
//  (local switch-allocator path plus SMART straight-bypass inputs).
//  Tracks per-VC downstream credits and grants at most one flit per cycle.
//  Once a header flit wins, the port stays locked to that source until its tail flit is granted.
//  Sits between router_two_stage output staging and the smart bypass mux of one output port.
// PARAMETERS
//  N   2  number of requesting flit sources (N>=2)
//  V   4  virtual channels per port; Vw = $clog2(V)
//  B   4  downstream buffer depth per VC (flits); Cw = $clog2(B+1)
//  LOCK_TIMEOUT  64  idle-lock cycle limit (used only with SS_ARB_WATCHDOG_EN)
// PORTS
//  clk            in   1      clock
//  reset          in   1      asynchronous, active-high reset
//  req            in   N      source i has a flit ready this cycle
//  req_vc         in   N*Vw   target downstream VC of source i (slice i*Vw +: Vw)
//  req_hdr        in   N      flit of source i is a header
//  req_tail       in   N      flit of source i is a tail (hdr&tail = single-flit packet)
//  credit_in      in   V      one credit returned per set bit, from downstream router
//  grant          out  N      one-hot or zero; source i may drive the port this cycle
//  flit_wr_o      out  1      |grant
//  credit_avail_o out  V      counter[v] != 0
//  locked_o       out  1      port held by an in-flight packet
//  owner_o        out  $clog2(N)  index of lock owner (valid when locked_o)
//  watchdog_err_o out  1      sticky lock-timeout flag (0 when macro off)
// BEHAVIOUR
//  - Reset: counters=B, locked_o=0, owner_o=0, rr pointer=0, watchdog_err_o=0.
//    grant/flit_wr_o forced 0 while reset is high, regardless of req.
//  - Eligible(i) = req[i] & counter[req_vc_i]!=0 & (locked ? i==owner : req_hdr[i]).
//    Body/tail flits from a non-owner are never granted; an unlocked source presenting a
//    non-header flit is ineligible.
//  - grant is combinational, same cycle as req (0-cycle latency). When unlocked, winner = first
//    eligible index at or after the rr pointer, wrapping N-1 -> 0.
//  - Pointer update on edge after a granted header: ptr <= winner+1 (mod N). No grant -> hold.
//  - Lock FSM, states UNLOCKED / LOCKED:
//      UNLOCKED -> LOCKED  : granted header with req_tail=0; owner <= winner.
//      LOCKED   -> UNLOCKED: owner's tail granted.
//      single-flit packet (hdr&tail) granted: stays UNLOCKED; pointer still advances.
//  - Credits, per VC v, updated at clock edge:
//      dec = grant to any source with req_vc==v; inc = credit_in[v].
//      dec&inc -> unchanged; dec only -> -1; inc only -> +1.
//      inc at counter==B -> saturate at B (overflow ignored).
//      dec at 0 impossible by eligibility.
//  - Owner whose VC has zero credits: port stays LOCKED, grant=0, other sources keep waiting.
//  - Reset asserted mid-packet: lock dropped, counters back to B. Upstream is reset together.
// CONFIGURATION
//  `define SS_ARB_WATCHDOG_EN:
//    Adds a counter of consecutive LOCKED cycles with no grant; cleared on any grant or unlock.
//    Reaching LOCK_TIMEOUT sets watchdog_err_o, which stays set until reset.
//    Arbitration is never altered by the watchdog.
//  Undefined: no counter logic; watchdog_err_o tied to 1'b0.
// TESTING
//  1. N=2,V=4,B=4; req=11, both hdr&tail vc0, held 4 cycles -> grants 01,10,01,10;
//     credit_avail_o[0]=0 after 4th; 5th cycle grant=00.
//  2. src0 hdr(vc1), no tail, 3 bodies, then tail, while src1 requests hdr every cycle
//     -> 5 consecutive grants to src0, locked_o=1 until tail edge; src1 granted cycle after tail.
//  3. Counter vc2 at 0, owner requesting vc2 -> grant=0, locked_o=1;
//     credit_in[2] pulse -> next cycle grant to owner.
//  4. Counter vc0=2, same-cycle grant on vc0 and credit_in[0]=1 -> counter stays 2;
//     credit_in[0] at counter=B -> stays B.
//  5. reset pulsed while locked mid-packet with counters at 1 -> locked_o=0,
//     credit_avail_o=1111, grant=0 during reset even with req=11.
//  6. With SS_ARB_WATCHDOG_EN, LOCK_TIMEOUT=8: lock then starve owner's VC 8 cycles
//     -> watchdog_err_o=1, sticky. Without macro -> watchdog_err_o stays 0.

Source files
------------

// File: rtl/ss_oport_pck_arbiter.sv
// Packet-level round-robin output-port arbiter with per-VC credit tracking and wormhole lock.
// Zero-cycle grant with no internal buffering; a source waits while it lacks credit or the port is locked.
// Optional lock-starvation watchdog: `define SS_ARB_WATCHDOG_EN.
module ss_oport_pck_arbiter #(
    parameter int N            = 2,
    parameter int V            = 4,
    parameter int B            = 4,
    parameter int LOCK_TIMEOUT = 64,
    localparam int VW          = (V > 1) ? $clog2(V) : 1,
    localparam int PW          = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*VW-1:0] req_vc,
    input  logic [N-1:0]    req_hdr,
    input  logic [N-1:0]    req_tail,
    input  logic [V-1:0]    credit_in,
    output logic [N-1:0]    grant,
    output logic            flit_wr_o,
    output logic [V-1:0]    credit_avail_o,
    output logic            locked_o,
    output logic [PW-1:0]   owner_o,
    output logic            watchdog_err_o
);

    localparam int CW = $clog2(B + 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t   state_q, state_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q [V];

    logic [N-1:0]  elig;
    logic [PW-1:0] win;
    logic          win_vld;
    logic [VW-1:0] win_vc;

    always_comb begin
        credit_avail_o = '0;
        for (int v = 0; v < V; v++) begin
            credit_avail_o[v] = (cnt_q[v] != '0);
        end
    end

    // While locked only the owner may proceed; otherwise only packet heads compete.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = req[i] && credit_avail_o[req_vc[i*VW +: VW]] &&
                      ((state_q == LOCKED) ? (owner_q == PW'(i)) : req_hdr[i]);
        end
    end

    // Scan downwards so the last hit is the first eligible index at or after the pointer.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (elig[(int'(ptr_q) + k) % N]) begin
                win     = PW'((int'(ptr_q) + k) % N);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (win_vld && !reset) begin
            grant[win] = 1'b1;
        end
    end

    assign flit_wr_o = |grant;
    assign win_vc    = req_vc[int'(win)*VW +: VW];
    assign locked_o  = (state_q == LOCKED);
    assign owner_o   = owner_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= UNLOCKED;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (flit_wr_o) begin
            case (state_q)
                UNLOCKED: begin
                    if (int'(win) == N - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win + PW'(1);
                    end
                    // A single-flit packet never takes the lock.
                    if (!req_tail[win]) begin
                        state_d = LOCKED;
                        owner_d = win;
                    end
                end
                LOCKED: begin
                    if (req_tail[win]) begin
                        state_d = UNLOCKED;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    // Credit returned in the same cycle as a send cancels out; returns beyond B are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < V; v++) begin
                cnt_q[v] <= CW'(B);
            end
        end else begin
            for (int v = 0; v < V; v++) begin
                if (credit_in[v] && !(flit_wr_o && (win_vc == VW'(v)))) begin
                    if (cnt_q[v] != CW'(B)) begin
                        cnt_q[v] <= cnt_q[v] + CW'(1);
                    end
                end else if (!credit_in[v] && flit_wr_o && (win_vc == VW'(v))) begin
                    cnt_q[v] <= cnt_q[v] - CW'(1);
                end
            end
        end
    end

`ifdef SS_ARB_WATCHDOG_EN
    localparam int WDW = $clog2(LOCK_TIMEOUT + 1);

    logic [WDW-1:0] wd_cnt_q;
    logic [WDW-1:0] wd_cnt_nxt;
    logic           wd_err_q;

    assign wd_cnt_nxt = (wd_cnt_q == WDW'(LOCK_TIMEOUT)) ? wd_cnt_q : wd_cnt_q + WDW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else if ((state_q != LOCKED) || flit_wr_o) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_nxt;
            if (wd_cnt_nxt == WDW'(LOCK_TIMEOUT)) begin
                wd_err_q <= 1'b1;
            end
        end
    end

    assign watchdog_err_o = wd_err_q;
`else
    localparam logic [31:0] LOCK_TIMEOUT_VEC = 32'(LOCK_TIMEOUT);

    logic unused_cfg;
    assign unused_cfg     = ^LOCK_TIMEOUT_VEC;
    assign watchdog_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ss_oport_pck_arbiter.sv
// Directed bench for ss_oport_pck_arbiter (N=2, V=4, B=4, LOCK_TIMEOUT=8).
module tb_ss_oport_pck_arbiter;

    localparam int N  = 2;
    localparam int V  = 4;
    localparam int VW = 2;
`ifdef SS_ARB_WATCHDOG_EN
    localparam logic WD_EXP = 1'b1;
`else
    localparam logic WD_EXP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*VW-1:0] req_vc;
    logic [N-1:0]    req_hdr;
    logic [N-1:0]    req_tail;
    logic [V-1:0]    credit_in;
    logic [N-1:0]    grant;
    logic            flit_wr_o;
    logic [V-1:0]    credit_avail_o;
    logic            locked_o;
    logic [0:0]      owner_o;
    logic            watchdog_err_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ss_oport_pck_arbiter #(.N(N), .V(V), .B(4), .LOCK_TIMEOUT(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_vc         (req_vc),
        .req_hdr        (req_hdr),
        .req_tail       (req_tail),
        .credit_in      (credit_in),
        .grant          (grant),
        .flit_wr_o      (flit_wr_o),
        .credit_avail_o (credit_avail_o),
        .locked_o       (locked_o),
        .owner_o        (owner_o),
        .watchdog_err_o (watchdog_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic r, input logic [VW-1:0] vc,
                           input logic h, input logic t);
        req[i]             = r;
        req_vc[i*VW +: VW] = vc;
        req_hdr[i]         = h;
        req_tail[i]        = t;
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_vc    = '0;
        req_hdr   = '0;
        req_tail  = '0;
        credit_in = '0;
        set_src(0, 1'b1, 2'd0, 1'b1, 1'b1);
        set_src(1, 1'b1, 2'd0, 1'b1, 1'b1);
        cyc();
        cyc();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_flit_wr", 32'(flit_wr_o), 32'h0);
        chk("rst_locked", 32'(locked_o), 32'h0);
        chk("rst_owner", 32'(owner_o), 32'h0);
        chk("rst_avail", 32'(credit_avail_o), 32'hf);
        chk("rst_wd", 32'(watchdog_err_o), 32'h0);

        // Single-flit packets from both sources alternate until vc0 runs dry.
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("rr_grant", 32'(grant), (c % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_locked", 32'(locked_o), 32'h0);
            cyc();
        end
        chk("rr_avail_vc0_empty", 32'(credit_avail_o), 32'he);
        #1;
        chk("rr_no_credit_grant", 32'(grant), 32'h0);
        chk("rr_no_credit_wr", 32'(flit_wr_o), 32'h0);
        req       = '0;
        credit_in = 4'b0001;
        for (int c = 0; c < 4; c++) cyc();
        credit_in = '0;
        chk("refill_vc0", 32'(credit_avail_o), 32'hf);

        // Five-flit packet from src0 holds the port against src1 headers.
        set_src(0, 1'b1, 2'd1, 1'b1, 1'b0);
        set_src(1, 1'b1, 2'd3, 1'b1, 1'b1);
        #1;
        chk("pkt_hdr_grant", 32'(grant), 32'h1);
        cyc();
        chk("pkt_locked", 32'(locked_o), 32'h1);
        chk("pkt_owner", 32'(owner_o), 32'h0);
        for (int b = 0; b < 3; b++) begin
            set_src(0, 1'b1, 2'd1, 1'b0, 1'b0);
            credit_in = (b == 0) ? 4'b0010 : 4'b0000;
            #1;
            chk("pkt_body_grant", 32'(grant), 32'h1);
            cyc();
            chk("pkt_body_locked", 32'(locked_o), 32'h1);
        end
        credit_in = '0;
        set_src(0, 1'b1, 2'd1, 1'b0, 1'b1);
        #1;
        chk("pkt_tail_grant", 32'(grant), 32'h1);
        chk("pkt_tail_locked", 32'(locked_o), 32'h1);
        cyc();
        chk("pkt_unlocked", 32'(locked_o), 32'h0);
        set_src(0, 1'b0, 2'd0, 1'b0, 1'b0);
        #1;
        chk("pkt_src1_grant", 32'(grant), 32'h2);
        cyc();
        set_src(1, 1'b0, 2'd3, 1'b0, 1'b0);
        chk("pkt_avail", 32'(credit_avail_o), 32'hd);

        // Owner starved on vc2 keeps the lock; a returned credit releases it next cycle.
        set_src(0, 1'b1, 2'd2, 1'b1, 1'b0);
        #1;
        chk("stv_hdr_grant", 32'(grant), 32'h1);
        cyc();
        for (int b = 0; b < 3; b++) begin
            set_src(0, 1'b1, 2'd2, 1'b0, 1'b0);
            #1;
            chk("stv_body_grant", 32'(grant), 32'h1);
            cyc();
        end
        chk("stv_avail", 32'(credit_avail_o), 32'h9);
        set_src(1, 1'b1, 2'd3, 1'b1, 1'b1);
        #1;
        chk("stv_zero_grant", 32'(grant), 32'h0);
        chk("stv_zero_locked", 32'(locked_o), 32'h1);
        cyc();
        credit_in = 4'b0100;
        #1;
        chk("stv_credit_cycle_grant", 32'(grant), 32'h0);
        cyc();
        credit_in = '0;
        set_src(1, 1'b0, 2'd3, 1'b0, 1'b0);
        set_src(0, 1'b1, 2'd2, 1'b0, 1'b1);
        #1;
        chk("stv_release_grant", 32'(grant), 32'h1);
        cyc();
        chk("stv_unlocked", 32'(locked_o), 32'h0);

        // vc0 brought to 2; a send with a simultaneous return leaves it at 2.
        set_src(0, 1'b1, 2'd0, 1'b1, 1'b1);
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("cr_fill_grant", 32'(grant), 32'h1);
            cyc();
        end
        credit_in = 4'b0001;
        #1;
        chk("cr_same_cycle_grant", 32'(grant), 32'h1);
        cyc();
        credit_in = '0;
        cyc();
        chk("cr_hold_one_left", 32'(credit_avail_o[0]), 32'h1);
        cyc();
        chk("cr_hold_empty", 32'(credit_avail_o[0]), 32'h0);
        #1;
        chk("cr_hold_no_grant", 32'(grant), 32'h0);
        // Five returns into an empty vc0 saturate at four.
        set_src(0, 1'b0, 2'd0, 1'b0, 1'b0);
        credit_in = 4'b0001;
        for (int c = 0; c < 5; c++) cyc();
        credit_in = '0;
        set_src(0, 1'b1, 2'd0, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("sat_drain_grant", 32'(grant), 32'h1);
            cyc();
        end
        chk("sat_empty", 32'(credit_avail_o[0]), 32'h0);
        #1;
        chk("sat_no_grant", 32'(grant), 32'h0);
        set_src(0, 1'b0, 2'd0, 1'b0, 1'b0);

        // Reset in the middle of a locked packet from src1.
        set_src(1, 1'b1, 2'd3, 1'b1, 1'b0);
        #1;
        chk("mr_hdr_grant", 32'(grant), 32'h2);
        cyc();
        chk("mr_locked", 32'(locked_o), 32'h1);
        chk("mr_owner", 32'(owner_o), 32'h1);
        set_src(1, 1'b1, 2'd3, 1'b0, 1'b0);
        cyc();
        chk("mr_avail_before", 32'(credit_avail_o), 32'h8);
        set_src(0, 1'b1, 2'd0, 1'b1, 1'b1);
        set_src(1, 1'b1, 2'd1, 1'b1, 1'b1);
        reset = 1'b1;
        #1;
        chk("mr_grant", 32'(grant), 32'h0);
        chk("mr_flit_wr", 32'(flit_wr_o), 32'h0);
        chk("mr_unlocked", 32'(locked_o), 32'h0);
        chk("mr_owner_clr", 32'(owner_o), 32'h0);
        chk("mr_avail", 32'(credit_avail_o), 32'hf);
        cyc();
        chk("mr_grant_held", 32'(grant), 32'h0);
        req   = '0;
        reset = 1'b0;

        // Lock on vc0, drain it, then starve the owner for eight cycles.
        set_src(0, 1'b1, 2'd0, 1'b1, 1'b0);
        #1;
        chk("wd_hdr_grant", 32'(grant), 32'h1);
        cyc();
        for (int b = 0; b < 3; b++) begin
            set_src(0, 1'b1, 2'd0, 1'b0, 1'b0);
            cyc();
        end
        #1;
        chk("wd_starve_grant", 32'(grant), 32'h0);
        for (int s = 1; s <= 8; s++) begin
            cyc();
            if (s == 7) chk("wd_before_timeout", 32'(watchdog_err_o), 32'h0);
        end
        chk("wd_timeout", 32'(watchdog_err_o), 32'(WD_EXP));
        chk("wd_still_locked", 32'(locked_o), 32'h1);
        credit_in = 4'b0001;
        set_src(0, 1'b1, 2'd0, 1'b0, 1'b1);
        cyc();
        credit_in = '0;
        #1;
        chk("wd_tail_grant", 32'(grant), 32'h1);
        cyc();
        chk("wd_tail_unlocked", 32'(locked_o), 32'h0);
        chk("wd_sticky", 32'(watchdog_err_o), 32'(WD_EXP));
        req = '0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
